// File: rtl/step_ctrl.sv
// CPU step/run controller: synchronized and debounced push button, short press
// issues a single step, long press toggles auto-run, plus a free-running scan tick.
module step_ctrl #(
    parameter int RUN_DIV        = 50000000,
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_CYC   = 1000000,
    parameter int LONG_PRESS_CYC = 50000000
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic button,
    output logic step_en,
    output logic scan_tick,
    output logic run_mode,
    output logic btn_db
);

    localparam int RUN_W  = $clog2(RUN_DIV + 1);
    localparam int SCAN_W = $clog2(SCAN_DIV + 1);
    localparam int DB_W   = $clog2(DEBOUNCE_CYC + 1);
    localparam int HOLD_W = $clog2(LONG_PRESS_CYC + 1);

    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(RUN_DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYC);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYC - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } state_t;

    state_t            state_q,    state_d;
    logic [1:0]        sync_q,     sync_d;
    logic [DB_W-1:0]   db_cnt_q,   db_cnt_d;
    logic [HOLD_W-1:0] hold_q,     hold_d;
    logic [RUN_W-1:0]  run_cnt_q,  run_cnt_d;
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic              btn_db_q,   btn_db_d;
    logic              run_mode_q, run_mode_d;
    logic              step_en_q,  step_en_d;
    logic              scan_tick_q, scan_tick_d;
    logic              toggle_s;
    logic              short_step_s;
    logic              run_wrap_s;

    // Next-state logic for synchronizer, debouncer, press FSM and both dividers
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        btn_db_d     = btn_db_q;
        db_cnt_d     = db_cnt_q;
        run_mode_d   = run_mode_q;
        run_cnt_d    = run_cnt_q;
        scan_cnt_d   = scan_cnt_q;
        scan_tick_d  = 1'b0;
        toggle_s     = 1'b0;
        short_step_s = 1'b0;
        run_wrap_s   = 1'b0;

        sync_d = {sync_q[0], button};

        if (sync_q[1] != btn_db_q) begin
            if (db_cnt_q == DB_LAST) begin
                btn_db_d = sync_q[1];
                db_cnt_d = '0;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end else begin
            db_cnt_d = '0;
        end

        case (state_q)
            IDLE: begin
                if (btn_db_q) begin
                    state_d = PRESSED;
                    hold_d  = HOLD_W'(1);
                end else begin
                    hold_d  = '0;
                end
            end
            PRESSED: begin
                if (!btn_db_q) begin
                    state_d      = IDLE;
                    hold_d       = '0;
                    short_step_s = ~run_mode_q;
                end else if (hold_q == HOLD_LAST) begin
                    state_d  = HELD;
                    hold_d   = HOLD_MAX;
                    toggle_s = 1'b1;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            HELD: begin
                if (!btn_db_q) begin
                    state_d = IDLE;
                    hold_d  = '0;
                end else begin
                    hold_d  = hold_q;
                end
            end
            default: begin
                state_d = IDLE;
                hold_d  = '0;
            end
        endcase

        // A toggle restarts the run divider so the first run pulse lands RUN_DIV later
        if (toggle_s) begin
            run_mode_d = ~run_mode_q;
            run_cnt_d  = '0;
        end else if (run_mode_q) begin
            if (run_cnt_q == RUN_LAST) begin
                run_cnt_d  = '0;
                run_wrap_s = 1'b1;
            end else begin
                run_cnt_d  = run_cnt_q + RUN_W'(1);
            end
        end else begin
            run_cnt_d = '0;
        end

        step_en_d = run_wrap_s | short_step_s;

        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d  = '0;
            scan_tick_d = 1'b1;
        end else begin
            scan_cnt_d  = scan_cnt_q + SCAN_W'(1);
        end
    end

    // State and registered outputs
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= IDLE;
            sync_q      <= 2'b00;
            db_cnt_q    <= '0;
            hold_q      <= '0;
            run_cnt_q   <= '0;
            scan_cnt_q  <= '0;
            btn_db_q    <= 1'b0;
            run_mode_q  <= 1'b1;
            step_en_q   <= 1'b0;
            scan_tick_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            db_cnt_q    <= db_cnt_d;
            hold_q      <= hold_d;
            run_cnt_q   <= run_cnt_d;
            scan_cnt_q  <= scan_cnt_d;
            btn_db_q    <= btn_db_d;
            run_mode_q  <= run_mode_d;
            step_en_q   <= step_en_d;
            scan_tick_q <= scan_tick_d;
        end
    end

    assign step_en   = step_en_q;
    assign scan_tick = scan_tick_q;
    assign run_mode  = run_mode_q;
    assign btn_db    = btn_db_q;

endmodule

// File: tb/tb_step_ctrl.sv
// Directed bench for step_ctrl with small divider/debounce parameters.
module tb_step_ctrl;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic button  = 1'b0;
    logic step_en, scan_tick, run_mode, btn_db;

    int total = 0;
    int bad   = 0;

    step_ctrl #(
        .RUN_DIV(8), .SCAN_DIV(5), .DEBOUNCE_CYC(4), .LONG_PRESS_CYC(20)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .button(button),
        .step_en(step_en), .scan_tick(scan_tick), .run_mode(run_mode), .btn_db(btn_db)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        button  = 1'b0;
        repeat (3) tick();
        sys_rst = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        button  = 1'b0;
        repeat (3) tick();
        total++;
        if ({step_en, scan_tick, btn_db, run_mode} !== 4'b0001) begin
            bad++;
            $display("FAIL reset_vals got=%b want=0001", {step_en, scan_tick, btn_db, run_mode});
        end
        sys_rst = 1'b0;
        for (int i = 1; i <= 25; i++) begin
            tick();
            total++;
            if (step_en !== ((i == 8) || (i == 16) || (i == 24))) begin
                bad++;
                $display("FAIL run_pulse cyc=%0d step_en=%b", i, step_en);
            end
            total++;
            if (scan_tick !== ((i % 5) == 0)) begin
                bad++;
                $display("FAIL scan_tick cyc=%0d scan_tick=%b", i, scan_tick);
            end
            total++;
            if (run_mode !== 1'b1) begin
                bad++;
                $display("FAIL run_mode_reset cyc=%0d run_mode=%b want=1", i, run_mode);
            end
        end
    endtask

    // Reset released together with press; hold 30 cycles, toggle at 26.
    task automatic test_long_from_run();
        do_reset();
        button = 1'b1;
        for (int i = 1; i <= 45; i++) begin
            tick();
            if (i == 30) button = 1'b0;
            total++;
            if (step_en !== ((i == 8) || (i == 16) || (i == 24))) begin
                bad++;
                $display("FAIL long_run_step cyc=%0d step_en=%b", i, step_en);
            end
            total++;
            if (run_mode !== (i < 26)) begin
                bad++;
                $display("FAIL long_run_mode cyc=%0d run_mode=%b want=%b", i, run_mode, (i < 26));
            end
            total++;
            if (btn_db !== ((i >= 6) && (i < 36))) begin
                bad++;
                $display("FAIL long_run_db cyc=%0d btn_db=%b", i, btn_db);
            end
        end
    endtask

    task automatic test_short_step();
        button = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            tick();
            if (i == 10) button = 1'b0;
            total++;
            if (step_en !== (i == 17)) begin
                bad++;
                $display("FAIL short_step cyc=%0d step_en=%b want=%b", i, step_en, (i == 17));
            end
            total++;
            if (btn_db !== ((i >= 6) && (i < 16))) begin
                bad++;
                $display("FAIL short_db cyc=%0d btn_db=%b", i, btn_db);
            end
            total++;
            if (run_mode !== 1'b0) begin
                bad++;
                $display("FAIL short_mode cyc=%0d run_mode=%b want=0", i, run_mode);
            end
        end
    endtask

    task automatic test_glitch();
        logic pat [0:24];
        for (int i = 0; i < 25; i++) pat[i] = 1'b0;
        for (int i = 0; i < 3; i++) pat[i] = 1'b1;
        for (int i = 5; i < 21; i++) pat[i] = ((i - 5) % 4) < 2;
        for (int i = 0; i < 35; i++) begin
            button = (i < 25) ? pat[i] : 1'b0;
            tick();
            total++;
            if ({btn_db, step_en} !== 2'b00) begin
                bad++;
                $display("FAIL glitch cyc=%0d btn_db=%b step_en=%b want=00", i, btn_db, step_en);
            end
        end
    endtask

    // From STEP: hold 25 toggles to RUN at 26; later short press is ignored.
    task automatic test_long_from_step();
        logic exp;
        button = 1'b1;
        for (int i = 1; i <= 62; i++) begin
            tick();
            if (i == 25) button = 1'b0;
            if (i == 36) button = 1'b1;
            if (i == 46) button = 1'b0;
            exp = (i >= 34) && (((i - 34) % 8) == 0);
            total++;
            if (step_en !== exp) begin
                bad++;
                $display("FAIL step_to_run cyc=%0d step_en=%b want=%b", i, step_en, exp);
            end
            total++;
            if (run_mode !== (i >= 26)) begin
                bad++;
                $display("FAIL step_to_run_mode cyc=%0d run_mode=%b want=%b", i, run_mode, (i >= 26));
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        button = 1'b1;
        repeat (30) tick();
        button = 1'b0;
        repeat (15) tick();
        total++;
        if (run_mode !== 1'b0) begin
            bad++;
            $display("FAIL midhold_pre run_mode=%b want=0", run_mode);
        end
        button = 1'b1;
        repeat (21) tick();
        sys_rst = 1'b1;
        #1;
        total++;
        if ({run_mode, btn_db, step_en} !== 3'b100) begin
            bad++;
            $display("FAIL midhold_rst got=%b want=100", {run_mode, btn_db, step_en});
        end
        repeat (3) tick();
        sys_rst = 1'b0;
        for (int i = 1; i <= 35; i++) begin
            tick();
            total++;
            if (step_en !== ((i == 8) || (i == 16) || (i == 24))) begin
                bad++;
                $display("FAIL midhold_step cyc=%0d step_en=%b", i, step_en);
            end
            total++;
            if (run_mode !== (i < 26)) begin
                bad++;
                $display("FAIL midhold_mode cyc=%0d run_mode=%b want=%b", i, run_mode, (i < 26));
            end
            total++;
            if (btn_db !== (i >= 6)) begin
                bad++;
                $display("FAIL midhold_db cyc=%0d btn_db=%b want=%b", i, btn_db, (i >= 6));
            end
        end
        button = 1'b0;
    endtask

    initial begin
        test_reset();
        test_long_from_run();
        test_short_step();
        test_glitch();
        test_long_from_step();
        test_reset_mid_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
